// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Provides default geometry and the write-commit qualifier used by both the
// storage write logic and the read forwarding mux, so they always agree.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_ADDR_W = 5;

  // A write commits only to an in-range address that is not the hard-wired zero.
  function automatic logic valid_wr(input logic [31:0] addr,
                                    input logic        zeroReg,
                                    input logic [31:0] depth);
    return (addr < depth) && !(zeroReg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port selection: out-of-range -> 0, zero register -> 0,
// same-cycle committing write -> that write's data (highest port wins),
// otherwise the stored array value.
// Ports:
//   rdAddr   - read address of this port
//   wrEn     - all write enables
//   wrAddr   - all write addresses, packed
//   wrData   - all write data, packed
//   arrData  - stored value read from the array at rdAddr
//   selData_c- selected read value (combinational)
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        rdAddr,
  input  logic [NUM_WR-1:0]        wrEn,
  input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
  input  logic [NUM_WR*DATA_W-1:0] wrData,
  input  logic [DATA_W-1:0]        arrData,
  output logic [DATA_W-1:0]        selData_c
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  // Later assignments override earlier ones, giving the priority order.
  always_comb begin
    selData_c = arrData;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (wrEn[j]
          && valid_wr(32'(wrAddr[j*ADDR_W +: ADDR_W]), ZERO_EN, 32'(DEPTH))
          && (wrAddr[j*ADDR_W +: ADDR_W] == rdAddr)) begin
        selData_c = wrData[j*DATA_W +: DATA_W];
      end
    end
    if (ZERO_EN && (rdAddr == '0)) begin
      selData_c = '0;
    end
    if (32'(rdAddr) >= 32'(DEPTH)) begin
      selData_c = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered, stall-holdable
// read ports and same-cycle write-to-read bypass.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   rd_en    - per-read-port enable; 0 holds the lane
//   rd_addr  - packed read addresses
//   rd_data  - packed registered read data
//   wr_en    - per-write-port enable
//   wr_addr  - packed write addresses
//   wr_data  - packed write data
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic        ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [DATA_W-1:0] rdDataQ [NUM_RD];
  logic [DATA_W-1:0] arrData [NUM_RD];
  logic [DATA_W-1:0] selData [NUM_RD];

  // Storage: reset clears everything; higher write ports land last and win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_en[j]
            && valid_wr(32'(wr_addr[j*ADDR_W +: ADDR_W]), ZERO_EN, 32'(DEPTH))) begin
          regs[IDX_W'(wr_addr[j*ADDR_W +: ADDR_W])] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] rdAddrI;
    assign rdAddrI = rd_addr[i*ADDR_W +: ADDR_W];

    // Array index is only meaningful in range; the mux zeroes the rest anyway.
    always_comb begin
      arrData[i] = '0;
      if (32'(rdAddrI) < 32'(DEPTH)) begin
        arrData[i] = regs[IDX_W'(rdAddrI)];
      end
    end

    regfile_fwd_mux #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_fwd (
      .rdAddr   (rdAddrI),
      .wrEn     (wr_en),
      .wrAddr   (wr_addr),
      .wrData   (wr_data),
      .arrData  (arrData[i]),
      .selData_c(selData[i])
    );

    // Read lane register; disabled lanes hold for pipeline stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdDataQ[i] <= '0;
      end else if (rd_en[i]) begin
        rdDataQ[i] <= selData[i];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rdDataQ[i];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DEPTH=24, two write ports).
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   rdEn;
  logic [NR*AW-1:0] rdAddr;
  logic [NR*DW-1:0] rdData;
  logic [NW-1:0]   wrEn;
  logic [NW*AW-1:0] wrAddr;
  logic [NW*DW-1:0] wrData;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W  (DW),
    .DEPTH   (24),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .NUM_WR  (NW),
    .ZERO_REG(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rdEn),
    .rd_addr(rdAddr),
    .rd_data(rdData),
    .wr_en  (wrEn),
    .wr_addr(wrAddr),
    .wr_data(wrData)
  );

  task automatic idle();
    rdEn = '0;
    wrEn = '0;
  endtask

  task automatic wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wrEn[j] = 1'b1;
    wrAddr[j*AW +: AW] = a;
    wrData[j*DW +: DW] = d;
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a);
    rdEn[i] = 1'b1;
    rdAddr[i*AW +: AW] = a;
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int lane, input logic [DW-1:0] exp);
    logic [DW-1:0] obs;
    obs = rdData[lane*DW +: DW];
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdEn = '0; rdAddr = '0; wrEn = '0; wrAddr = '0; wrData = '0;
    tick();
    check("reset_lane0", 0, 32'h0);
    check("reset_lane1", 1, 32'h0);
    rst = 1'b0;

    // Reset clears stored data and discards same-cycle writes
    idle(); wr(0, 5'd5, 32'hDEADBEEF); tick();
    idle(); rd(0, 5'd5); tick();
    check("r5_written", 0, 32'hDEADBEEF);
    idle(); rst = 1'b1; wr(0, 5'd7, 32'h00000077); rd(0, 5'd5); tick();
    check("rst_clears_lane", 0, 32'h0);
    rst = 1'b0;
    idle(); rd(0, 5'd5); rd(1, 5'd7); tick();
    check("r5_after_rst", 0, 32'h0);
    check("r7_rst_write_dropped", 1, 32'h0);

    // Basic write then read
    idle(); wr(0, 5'd3, 32'h12345678); tick();
    idle(); rd(1, 5'd3); tick();
    check("basic_r3", 1, 32'h12345678);

    // Zero register
    idle(); wr(1, 5'd0, 32'hFFFFFFFF); tick();
    idle(); rd(0, 5'd0); tick();
    check("r0_reads_zero", 0, 32'h0);
    idle(); wr(0, 5'd0, 32'hFFFFFFFF); rd(1, 5'd0); tick();
    check("r0_no_bypass", 1, 32'h0);

    // Out-of-range address
    idle(); wr(0, 5'd6, 32'h66666666); tick();
    idle(); wr(0, 5'd30, 32'h000000AA); rd(0, 5'd30); tick();
    check("oob_bypass_zero", 0, 32'h0);
    idle(); rd(0, 5'd30); rd(1, 5'd6); tick();
    check("oob_reads_zero", 0, 32'h0);
    check("r6_unaliased", 1, 32'h66666666);

    // Same-cycle bypass on both read ports
    idle(); wr(0, 5'd9, 32'hCAFE0001); rd(0, 5'd9); rd(1, 5'd9); tick();
    check("bypass_lane0", 0, 32'hCAFE0001);
    check("bypass_lane1", 1, 32'hCAFE0001);

    // Dual-write conflict: highest port wins
    idle(); wr(0, 5'd4, 32'h00001111); wr(1, 5'd4, 32'h00002222); rd(0, 5'd4); tick();
    check("conflict_bypass", 0, 32'h00002222);
    idle(); tick();
    idle(); rd(1, 5'd4); tick();
    check("conflict_stored", 1, 32'h00002222);
    // Invalid high-port write does not shadow a valid low-port write
    idle(); wr(0, 5'd4, 32'h00003333); wr(1, 5'd0, 32'h00004444); rd(0, 5'd4); tick();
    check("conflict_invalid_hi", 0, 32'h00003333);
    idle(); wr(0, 5'd11, 32'h0000AAAA); wr(1, 5'd28, 32'h0000BBBB); rd(1, 5'd11); tick();
    check("conflict_oob_hi", 1, 32'h0000AAAA);

    // Stall hold
    idle(); wr(1, 5'd2, 32'h00000055); tick();
    idle(); rd(0, 5'd2); tick();
    check("stall_initial", 0, 32'h00000055);
    idle(); rdAddr[0 +: AW] = 5'd9; wr(0, 5'd2, 32'h00000066); tick();
    check("stall_hold1", 0, 32'h00000055);
    idle(); rdAddr[0 +: AW] = 5'd3; tick();
    check("stall_hold2", 0, 32'h00000055);
    idle(); rdAddr[0 +: AW] = 5'd4; tick();
    check("stall_hold3", 0, 32'h00000055);
    idle(); rd(0, 5'd2); tick();
    check("stall_release", 0, 32'h00000066);

    idle(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
